// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory handshake with timeout trap, illegal-opcode trap and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int OPCODE_W     = 7,
    parameter int ALUOP_W      = 2,
    parameter int CNT_W        = 16,
    parameter int MEM_TIMEOUT  = 8,
    parameter int ENABLE_ITYPE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] instr_op,
    input  logic                mem_ready,
    output logic                Branch,
    output logic                MemRead,
    output logic                MemToReg,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                MemWrite,
    output logic                ALUSrc,
    output logic                RegWrite,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                illegal_op,
    output logic                mem_timeout,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    retired
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_ALU   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_ITYPE  = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

    // Counter only needs to reach MEM_TIMEOUT-1: the cycle that would hit the limit traps instead.
    localparam int                WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    logic [3:0]          state_q,   state_d;
    logic [OPCODE_W-1:0] op_q,      op_d;
    logic [WAIT_W-1:0]   wait_q,    wait_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                illegal_q, illegal_d;
    logic                timeout_q, timeout_d;
    logic                retire_s;
    logic                waiting_s;

    // Next-state, trap flags, wait counter and retire counter.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        retire_s  = 1'b0;
        waiting_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            S_DECODE: begin
                op_d = instr_op;
                case (instr_op)
                    OP_RTYPE: state_d = S_EXEC_R;
                    OP_ITYPE: begin
                        if (ENABLE_ITYPE != 0) begin
                            state_d = S_EXEC_I;
                        end else begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    end
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR: begin
                if (op_q == OP_LOAD) begin
                    state_d = S_MEM_RD;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    retire_s = 1'b1;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        if (waiting_s && (MEM_TIMEOUT != 0) && (wait_q == WAIT_LIMIT)) begin
            state_d   = S_TRAP;
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_d;
        end

        if (waiting_s && (state_d == state_q)) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = {WAIT_W{1'b0}};
        end

        if (retire_s) begin
            retired_d = retired_q + CNT_W'(1);
        end else begin
            retired_d = retired_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= {OPCODE_W{1'b0}};
            wait_q    <= {WAIT_W{1'b0}};
            retired_q <= {CNT_W{1'b0}};
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Moore control decode; everything is held low while reset is asserted.
    always_comb begin
        Branch   = 1'b0;
        MemRead  = 1'b0;
        MemToReg = 1'b0;
        ALUOp    = ALU_ADD;
        MemWrite = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        if (reset) begin
            ALUOp = ALU_ADD;
        end else begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_EXEC_R: ALUOp = ALU_FUNCT;
                S_EXEC_I: begin
                    ALUOp  = ALU_FUNCT;
                    ALUSrc = 1'b1;
                end
                S_MEM_ADDR: ALUSrc = 1'b1;
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    ALUSrc  = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    ALUSrc   = 1'b1;
                end
                S_WB_ALU: RegWrite = 1'b1;
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                S_BRANCH: begin
                    Branch = 1'b1;
                    ALUOp  = ALU_SUB;
                end
                default: ALUOp = ALU_ADD;
            endcase
        end
    end

    assign state       = state_q;
    assign retired     = retired_q;
    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Instruction-level reference bench: each instruction is expanded into its phase sequence
// and every cycle's state, controls, counter and trap flags are compared.
module tb_multicycle_control_unit;

    localparam int TO = 4;
    localparam int CW = 3;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_ALU   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    instr_op;
    logic          mem_ready;
    logic          Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, PCWrite, IRWrite;
    logic [1:0]    ALUOp;
    logic          illegal_op, mem_timeout;
    logic [3:0]    state;
    logic [CW-1:0] retired;

    int checks   = 0;
    int failures = 0;
    int model_retired;
    bit model_illegal;
    bit model_timeout;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .OPCODE_W(7), .ALUOP_W(2), .CNT_W(CW), .MEM_TIMEOUT(TO), .ENABLE_ITYPE(1)
    ) u_dut (
        .clk(clk), .reset(reset), .instr_op(instr_op), .mem_ready(mem_ready),
        .Branch(Branch), .MemRead(MemRead), .MemToReg(MemToReg), .ALUOp(ALUOp),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .PCWrite(PCWrite),
        .IRWrite(IRWrite), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .state(state), .retired(retired)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {Branch,MemRead,MemToReg,ALUOp,MemWrite,ALUSrc,RegWrite,PCWrite,IRWrite}
    function automatic logic [9:0] exp_ctrl(input logic [3:0] st, input logic rdy);
        case (st)
            S_FETCH:    return {1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, rdy,  rdy};
            S_EXEC_R:   return {1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            S_EXEC_I:   return {1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            S_MEM_ADDR: return {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            S_MEM_RD:   return {1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            S_MEM_WR:   return {1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            S_WB_ALU:   return {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            S_WB_MEM:   return {1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            S_BRANCH:   return {1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            default:    return 10'd0;
        endcase
    endfunction

    function automatic logic [9:0] ctrl_now();
        return {Branch, MemRead, MemToReg, ALUOp, MemWrite, ALUSrc, RegWrite, PCWrite, IRWrite};
    endfunction

    function automatic logic [6:0] rand_op();
        return 7'($urandom);
    endfunction

    task automatic check_all(input string pfx, input logic [3:0] st, input logic [9:0] ctrl);
        check_value({pfx, "state"}, 32'(state), 32'(st));
        check_value({pfx, "ctrl"}, 32'(ctrl_now()), 32'(ctrl));
        check_value({pfx, "retired"}, 32'(retired), 32'(model_retired));
        check_value({pfx, "flags"}, 32'({illegal_op, mem_timeout}), 32'({model_illegal, model_timeout}));
    endtask

    // Called right after a falling edge; one full clock per call.
    task automatic run_cycle(input logic [3:0] st, input logic rdy, input logic [6:0] op);
        mem_ready = rdy;
        instr_op  = op;
        #1;
        check_all("", st, exp_ctrl(st, rdy));
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_retired = 0;
        model_illegal = 1'b0;
        model_timeout = 1'b0;
        check_all("rst_", S_FETCH, 10'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check_all("rst_hold_", S_FETCH, 10'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_instr(input logic [6:0] op, input int nw_fetch, input int nw_mem,
                            input int abort_at, input int ntrap);
        logic [3:0] ph[$];
        int  cyc;
        int  nw;
        int  n0;
        bit  trapped;
        bit  legal;
        cyc     = 0;
        trapped = 1'b0;
        legal   = 1'b1;
        ph.push_back(S_FETCH);
        ph.push_back(S_DECODE);
        case (op)
            OP_R:  begin ph.push_back(S_EXEC_R); ph.push_back(S_WB_ALU); end
            OP_I:  begin ph.push_back(S_EXEC_I); ph.push_back(S_WB_ALU); end
            OP_LD: begin ph.push_back(S_MEM_ADDR); ph.push_back(S_MEM_RD); ph.push_back(S_WB_MEM); end
            OP_ST: begin ph.push_back(S_MEM_ADDR); ph.push_back(S_MEM_WR); end
            OP_BR: ph.push_back(S_BRANCH);
            default: legal = 1'b0;
        endcase
        foreach (ph[i]) begin
            if (trapped) break;
            if (ph[i] == S_FETCH || ph[i] == S_MEM_RD || ph[i] == S_MEM_WR) begin
                nw = (ph[i] == S_FETCH) ? nw_fetch : nw_mem;
                n0 = (TO != 0 && nw >= TO) ? TO : nw;
                for (int k = 0; k < n0; k++) begin
                    if (cyc == abort_at) begin do_reset(); return; end
                    cyc++;
                    run_cycle(ph[i], 1'b0, rand_op());
                end
                if (TO != 0 && nw >= TO) begin
                    model_timeout = 1'b1;
                    trapped       = 1'b1;
                end else begin
                    if (cyc == abort_at) begin do_reset(); return; end
                    cyc++;
                    run_cycle(ph[i], 1'b1, rand_op());
                end
            end else begin
                if (cyc == abort_at) begin do_reset(); return; end
                cyc++;
                run_cycle(ph[i], 1'($urandom), (ph[i] == S_DECODE) ? op : rand_op());
                if (ph[i] == S_DECODE && !legal) begin
                    model_illegal = 1'b1;
                    trapped       = 1'b1;
                end
            end
        end
        if (trapped) begin
            for (int n = 0; n < ntrap; n++) run_cycle(S_TRAP, 1'($urandom), rand_op());
            do_reset();
        end else begin
            model_retired = (model_retired + 1) % (1 << CW);
        end
    endtask

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return OP_R;
            1:       return OP_I;
            2:       return OP_LD;
            3:       return OP_ST;
            4:       return OP_BR;
            default: return rand_op();
        endcase
    endfunction

    function automatic int pick_wait();
        if ($urandom_range(0, 9) == 0) return TO + int'($urandom_range(0, 1));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b0;
        instr_op  = 7'd0;
        model_retired = 0;
        model_illegal = 1'b0;
        model_timeout = 1'b0;
        @(negedge clk);
        do_reset();

        repeat (3) do_instr(OP_R, 0, 0, -1, 0);
        check_value("rtype_retired3", 32'(retired), 32'd3);
        do_instr(OP_I, 0, 0, -1, 0);
        do_instr(OP_LD, 0, 3, -1, 0);
        do_instr(OP_ST, 0, 0, -1, 0);
        do_instr(7'b1111111, 0, 0, -1, 20);
        do_instr(OP_R, 4, 0, -1, 3);
        do_instr(OP_R, 3, 0, -1, 0);
        do_instr(OP_LD, 0, 4, -1, 2);
        do_instr(OP_ST, 1, 5, -1, 2);
        repeat (10) do_instr(OP_BR, 0, 0, -1, 0);
        do_instr(OP_R, 0, 0, 3, 0);
        do_instr(OP_ST, 1, 2, 5, 0);
        do_instr(OP_LD, 0, 0, 4, 0);

        repeat (300) begin
            do_instr(pick_op(), pick_wait(), pick_wait(),
                     ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 6)) : -1,
                     int'($urandom_range(1, 4)));
        end
        do_instr(OP_BR, 0, 0, -1, 0);
        run_cycle(S_FETCH, 1'b0, 7'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle RV32I control unit. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. It waits on a memory-ready handshake with a programmable timeout and traps on illegal opcodes. It sits between the instruction register and the datapath mux and enable controls, and counts retired instructions for performance monitoring.

Parameters:
OPCODE_W, 7, opcode field width.
ALUOP_W, 2, ALUOp width. 00 = add, 01 = sub/compare, 10 = funct-decoded.
CNT_W, 16, retired-instruction counter width.
MEM_TIMEOUT, 8, maximum wait cycles for mem_ready. 0 disables the timeout.
ENABLE_ITYPE, 1, when 1 decodes OP-IMM (0010011). When 0 that opcode is illegal.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
instr_op  input  OPCODE_W  opcode from the instruction register, sampled in DECODE
mem_ready  input  1  memory completion strobe for the current fetch, load or store
Branch  output  1  branch compare enable
MemRead  output  1  memory read request
MemToReg  output  1  writeback select: 1 = memory data, 0 = ALU result
ALUOp  output  ALUOP_W  ALU operation class
MemWrite  output  1  memory write request
ALUSrc  output  1  ALU B operand: 1 = immediate, 0 = rs2
RegWrite  output  1  register file write enable
PCWrite  output  1  PC <= PC+4
IRWrite  output  1  instruction register load
illegal_op  output  1  sticky flag: illegal opcode trap
mem_timeout  output  1  sticky flag: memory handshake timeout trap
state  output  4  current state encoding, for debug
retired  output  CNT_W  retired-instruction count

Behaviour:
- Reset (asynchronous, while reset=1):
  - state=FETCH, op_q=0, wait_cnt=0, retired=0, illegal_op=0, mem_timeout=0.
  - All control outputs are forced to 0 while reset is high.
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, TRAP=15.
- Control outputs are a combinational function of state. Exceptions: IRWrite and PCWrite also depend on mem_ready. Any output not listed for a state is 0.
- FETCH:
  - MemRead=1.
  - IRWrite = PCWrite = mem_ready.
  - mem_ready=1 -> DECODE.
- DECODE:
  - No outputs asserted.
  - op_q <= instr_op.
  - Next state by instr_op:
    - 0110011 -> EXEC_R.
    - 0010011 -> EXEC_I if ENABLE_ITYPE, else TRAP.
    - 0000011 or 0100011 -> MEM_ADDR.
    - 1100011 -> BRANCH.
    - Any other opcode -> TRAP, with illegal_op <= 1.
- EXEC_R: ALUOp=10, ALUSrc=0 -> WB_ALU.
- EXEC_I: ALUOp=10, ALUSrc=1 -> WB_ALU.
- MEM_ADDR: ALUOp=00, ALUSrc=1. Goes to MEM_RD if op_q=0000011, else MEM_WR.
- MEM_RD: MemRead=1, ALUSrc=1. Goes to WB_MEM on mem_ready.
- MEM_WR: MemWrite=1, ALUSrc=1. Goes to FETCH on mem_ready and retires.
- WB_ALU: RegWrite=1, MemToReg=0 -> FETCH, retires.
- WB_MEM: RegWrite=1, MemToReg=1 -> FETCH, retires.
- BRANCH: Branch=1, ALUOp=01, ALUSrc=0 -> FETCH, retires.
- TRAP:
  - All control outputs 0.
  - Absorbing state; only reset leaves it.
  - illegal_op and mem_timeout hold their values.
- Retire: retired increments by 1 on the transition into FETCH. Wraps from 2^CNT_W-1 to 0.
- Wait counter:
  - Counts cycles spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Clears on every state change.
  - If MEM_TIMEOUT != 0 and wait_cnt reaches MEM_TIMEOUT with mem_ready still 0: go to TRAP and set mem_timeout <= 1.
  - mem_ready=1 in the same cycle as the limit wins; there is no trap.
- mem_ready is ignored in states other than FETCH, MEM_RD and MEM_WR.
- Latency with zero-wait memory (mem_ready tied to 1):
  - R-type and I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each wait cycle adds 1.
- Reset asserted mid-instruction aborts immediately. After release, the FSM resumes at FETCH with no partial RegWrite or MemWrite.

Test Plan:
1. reset pulse, then mem_ready=1 and instr_op=0110011 repeated -> states cycle 0,1,2,7. RegWrite=1 only in state 7, ALUOp=10 in state 2. retired=3 after 12 cycles.
2. Load (0000011) with mem_ready held 0 for 3 cycles in MEM_RD -> MemRead high for 4 cycles in state 5, then WB_MEM with MemToReg=1 and RegWrite=1. Total 8 cycles.
3. Store (0100011) with mem_ready=1 -> MemWrite=1 for exactly 1 cycle. RegWrite is never asserted. retired increments by 1 after 4 cycles.
4. instr_op=1111111 in DECODE -> state=15 and illegal_op=1. All control outputs stay 0 for 20 further cycles. Async reset then clears both immediately.
5. MEM_TIMEOUT=4 with mem_ready=0 in FETCH -> TRAP after 4 wait cycles with mem_timeout=1. Repeat with mem_ready=1 on the limit cycle -> DECODE, no trap.
6. CNT_W=2 with 5 branches (1100011) -> retired sequence 1,2,3,0,1. Branch=1 and ALUOp=01 in state 9 only.
